// File: rtl/noc_pkg.sv
// Shared NoC link definitions: default channel/flit sizing and the stored flit layout.
package noc_pkg;

    localparam int NOC_CHANNELS   = 2;
    localparam int NOC_FLIT_WIDTH = 34;

    typedef struct packed {
        logic                      last;
        logic [NOC_FLIT_WIDTH-1:0] data;
    } flit_t;

endpackage

// File: rtl/noc_link_fifo.sv
// Single-channel link FIFO with optional store-and-forward gating and oversize
// cut-through fallback for packets that cannot fit in the buffer.
module noc_link_fifo
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH  = NOC_FLIT_WIDTH,
    parameter int DEPTH       = 4,
    parameter int PACKET_MODE = 0,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW-1:0]         fill_level,
    output logic                  oversize
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic                  last;
        logic [FLIT_WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, pkt_cnt;
    logic            cutthru;
    logic            full, wr_en, rd_en, over_hit;
    logic            pkt_inc, pkt_dec;

    always_comb begin
        head      = mem[rd_ptr];
        full      = (count == CW'(DEPTH));
        in_ready  = !full;
        wr_en     = in_valid && !full;
        // A full buffer holding no complete packet can never become presentable:
        // fall back to cut-through until that packet's last flit leaves.
        over_hit  = (PACKET_MODE != 0) && full && (pkt_cnt == '0) && !cutthru;
        out_valid = (count != '0) && ((PACKET_MODE == 0) || (pkt_cnt != '0) || cutthru);
        rd_en     = out_valid && out_ready;
        pkt_inc   = wr_en && in_last;
        pkt_dec   = rd_en && head.last;
    end

    assign out_flit   = head.data;
    assign out_last   = head.last;
    assign fill_level = count;
    assign oversize   = over_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pkt_cnt <= '0;
            cutthru <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= '{last: in_last, data: in_flit};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
            if (over_hit) begin
                cutthru <= 1'b1;
            end else if (pkt_dec) begin
                cutthru <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/noc_link_buffer.sv
// Multi-channel elastic buffer for tile<->NoC links: one independent FIFO per
// virtual channel, no cross-channel interaction.
module noc_link_buffer
    import noc_pkg::*;
#(
    parameter int CHANNELS    = NOC_CHANNELS,
    parameter int FLIT_WIDTH  = NOC_FLIT_WIDTH,
    parameter int DEPTH       = 4,
    parameter int PACKET_MODE = 0,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
    input  logic [CHANNELS-1:0]                  in_last,
    input  logic [CHANNELS-1:0]                  in_valid,
    output logic [CHANNELS-1:0]                  in_ready,
    output logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit,
    output logic [CHANNELS-1:0]                  out_last,
    output logic [CHANNELS-1:0]                  out_valid,
    input  logic [CHANNELS-1:0]                  out_ready,
    output logic [CHANNELS-1:0][CW-1:0]          fill_level,
    output logic [CHANNELS-1:0]                  oversize
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        noc_link_fifo #(
            .FLIT_WIDTH  (FLIT_WIDTH),
            .DEPTH       (DEPTH),
            .PACKET_MODE (PACKET_MODE)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .in_flit    (in_flit[c]),
            .in_last    (in_last[c]),
            .in_valid   (in_valid[c]),
            .in_ready   (in_ready[c]),
            .out_flit   (out_flit[c]),
            .out_last   (out_last[c]),
            .out_valid  (out_valid[c]),
            .out_ready  (out_ready[c]),
            .fill_level (fill_level[c]),
            .oversize   (oversize[c])
        );
    end

endmodule

// File: tb/tb_noc_link_buffer.sv
// Bench for noc_link_buffer: a cut-through and a store-and-forward instance
// checked against a queue-based model of the link buffer rules.
module tb_noc_link_buffer;
    import noc_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0][1:0][33:0]  in_flit, out_flit;
    logic [1:0][1:0]        in_last, in_valid, in_ready, out_last, out_valid, out_ready, oversize;
    logic [1:0][1:0][2:0]   fill_level;

    flit_t q [2][2][$];
    bit    cut  [2][2];
    bit    held [2][2];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    noc_link_buffer #(.CHANNELS(2), .FLIT_WIDTH(34), .DEPTH(4), .PACKET_MODE(0)) dut_ct (
        .clk(clk), .rst(rst),
        .in_flit(in_flit[0]), .in_last(in_last[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_flit(out_flit[0]), .out_last(out_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .fill_level(fill_level[0]), .oversize(oversize[0])
    );

    noc_link_buffer #(.CHANNELS(2), .FLIT_WIDTH(34), .DEPTH(4), .PACKET_MODE(1)) dut_pk (
        .clk(clk), .rst(rst),
        .in_flit(in_flit[1]), .in_last(in_last[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_flit(out_flit[1]), .out_last(out_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .fill_level(fill_level[1]), .oversize(oversize[1])
    );

    // ---------------- reference model (d: 0 = cut-through, 1 = packet mode)
    function automatic int nlast(int d, int c);
        int n = 0;
        for (int i = 0; i < q[d][c].size(); i++) if (q[d][c][i].last) n++;
        return n;
    endfunction

    function automatic bit m_valid(int d, int c);
        return q[d][c].size() > 0 && (d == 0 || nlast(d, c) > 0 || cut[d][c]);
    endfunction

    function automatic bit m_ready(int d, int c);
        return q[d][c].size() < 4;
    endfunction

    function automatic bit m_over(int d, int c);
        return d == 1 && q[d][c].size() == 4 && nlast(d, c) == 0 && !cut[d][c];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                q[d][c].delete();
                cut[d][c]  = 1'b0;
                held[d][c] = 1'b0;
            end
    endtask

    task automatic idle();
        in_flit = '0; in_last = '0; in_valid = '0; out_ready = '0;
    endtask

    // Advance one clock edge, applying the same edge to the model first.
    task automatic tick();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                bit wr, rd, ov;
                flit_t f;
                wr = in_valid[d][c] && m_ready(d, c);
                rd = out_ready[d][c] && m_valid(d, c);
                ov = m_over(d, c);
                held[d][c] = in_valid[d][c] && !wr;
                if (ov) cut[d][c] = 1'b1;
                if (rd) begin
                    f = q[d][c].pop_front();
                    if (f.last) cut[d][c] = 1'b0;
                end
                if (wr) q[d][c].push_back({in_last[d][c], in_flit[d][c]});
            end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests
    task automatic test_reset();
        rst = 1'b0;
        idle();
        model_reset();
        #3;
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (in_ready[d] !== 2'b11) begin n_bad++; $display("FAIL reset_in_ready d%0d: got %b want 11", d, in_ready[d]); end
            n_cmp++; if (out_valid[d] !== 2'b00) begin n_bad++; $display("FAIL reset_out_valid d%0d: got %b want 00", d, out_valid[d]); end
            n_cmp++; if (fill_level[d] !== 6'd0) begin n_bad++; $display("FAIL reset_fill d%0d: got %h want 0", d, fill_level[d]); end
            n_cmp++; if (oversize[d] !== 2'b00) begin n_bad++; $display("FAIL reset_oversize d%0d: got %b want 00", d, oversize[d]); end
            n_cmp++; if (out_flit[d] !== '0) begin n_bad++; $display("FAIL reset_out_flit d%0d: got %h want 0", d, out_flit[d]); end
            n_cmp++; if (out_last[d] !== 2'b00) begin n_bad++; $display("FAIL reset_out_last d%0d: got %b want 00", d, out_last[d]); end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_cut_fill();
        idle();
        for (int i = 0; i < 4; i++) begin
            in_valid[0][0] = 1'b1;
            in_flit[0][0]  = 34'hA + 34'(i);
            tick();
            if (i == 0) begin
                n_cmp++; if (out_valid[0][0] !== 1'b1) begin n_bad++; $display("FAIL ct_first_latency: got %b want 1", out_valid[0][0]); end
            end
        end
        in_flit[0][0] = 34'hE;
        n_cmp++; if (fill_level[0][0] !== 3'd4) begin n_bad++; $display("FAIL ct_fill_full: got %0d want 4", fill_level[0][0]); end
        n_cmp++; if (in_ready[0][0] !== 1'b0) begin n_bad++; $display("FAIL ct_ready_full: got %b want 0", in_ready[0][0]); end
        n_cmp++; if (in_ready[0][1] !== 1'b1 || fill_level[0][1] !== 3'd0 || out_valid[0][1] !== 1'b0) begin
            n_bad++; $display("FAIL ct_ch1_isolated: got ready=%b fill=%0d valid=%b want 1 0 0", in_ready[0][1], fill_level[0][1], out_valid[0][1]);
        end
        tick();
        n_cmp++; if (fill_level[0][0] !== 3'd4) begin n_bad++; $display("FAIL ct_no_write_full: got %0d want 4", fill_level[0][0]); end
        in_valid[0][0]  = 1'b0;
        out_ready[0][0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid[0][0] !== 1'b1 || out_flit[0][0] !== 34'hA + 34'(i)) begin
                n_bad++; $display("FAIL ct_drain_%0d: got valid=%b flit=%h want 1 %h", i, out_valid[0][0], out_flit[0][0], 34'hA + 34'(i));
            end
            tick();
        end
        n_cmp++; if (out_valid[0][0] !== 1'b0 || fill_level[0][0] !== 3'd0) begin
            n_bad++; $display("FAIL ct_empty: got valid=%b fill=%0d want 0 0", out_valid[0][0], fill_level[0][0]);
        end
        idle();
    endtask

    task automatic test_simul_rw();
        idle();
        in_valid[0][1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_flit[0][1] = 34'd200 + 34'(i);
            tick();
        end
        out_ready[0][1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_flit[0][1] = 34'd202 + 34'(k);
            n_cmp++; if (fill_level[0][1] !== 3'd2 || out_flit[0][1] !== 34'd200 + 34'(k)) begin
                n_bad++; $display("FAIL rw_steady_%0d: got fill=%0d flit=%0d want 2 %0d", k, fill_level[0][1], out_flit[0][1], 200 + k);
            end
            tick();
        end
        in_valid[0][1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (out_valid[0][1] !== 1'b1 || out_flit[0][1] !== 34'd210 + 34'(k)) begin
                n_bad++; $display("FAIL rw_tail_%0d: got valid=%b flit=%0d want 1 %0d", k, out_valid[0][1], out_flit[0][1], 210 + k);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_packet();
        idle();
        out_ready[1][0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[1][0] = 1'b1;
            in_flit[1][0]  = 34'h300 + 34'(i);
            in_last[1][0]  = (i == 2);
            tick();
            n_cmp++; if (out_valid[1][0] !== (i == 2)) begin
                n_bad++; $display("FAIL pkt_gate_%0d: got %b want %b", i, out_valid[1][0], i == 2);
            end
        end
        in_valid[1][0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid[1][0] !== 1'b1 || out_flit[1][0] !== 34'h300 + 34'(i) || out_last[1][0] !== (i == 2)) begin
                n_bad++; $display("FAIL pkt_stream_%0d: got v=%b f=%h l=%b want 1 %h %b", i, out_valid[1][0], out_flit[1][0], out_last[1][0], 34'h300 + 34'(i), i == 2);
            end
            tick();
        end
        n_cmp++; if (out_valid[1][0] !== 1'b0) begin n_bad++; $display("FAIL pkt_done: got %b want 0", out_valid[1][0]); end
        idle();
    endtask

    task automatic test_oversize();
        int pulses = 0, sent = 0, got = 0;
        bit accepted;
        idle();
        for (int i = 0; i < 4; i++) begin
            in_valid[1][1] = 1'b1;
            in_flit[1][1]  = 34'h400 + 34'(i);
            tick();
            sent++;
            if (oversize[1][1]) pulses++;
        end
        n_cmp++; if (oversize[1][1] !== 1'b1 || out_valid[1][1] !== 1'b0) begin
            n_bad++; $display("FAIL ovs_at_full: got oversize=%b valid=%b want 1 0", oversize[1][1], out_valid[1][1]);
        end
        in_flit[1][1]   = 34'h404;
        out_ready[1][1] = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (out_valid[1][1]) begin
                n_cmp++; if (out_flit[1][1] !== 34'h400 + 34'(got) || out_last[1][1] !== (got == 5)) begin
                    n_bad++; $display("FAIL ovs_flit_%0d: got f=%h l=%b want %h %b", got, out_flit[1][1], out_last[1][1], 34'h400 + 34'(got), got == 5);
                end
                got++;
            end
            accepted = in_valid[1][1] && in_ready[1][1];
            tick();
            if (oversize[1][1]) pulses++;
            if (accepted) begin
                sent++;
                in_flit[1][1]  = 34'h400 + 34'(sent);
                in_last[1][1]  = (sent == 5);
                in_valid[1][1] = (sent < 6);
            end
        end
        n_cmp++; if (got !== 6) begin n_bad++; $display("FAIL ovs_delivered: got %0d want 6", got); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ovs_pulses: got %0d want 1", pulses); end
        in_valid[1][1] = 1'b1;
        in_flit[1][1]  = 34'h500;
        in_last[1][1]  = 1'b0;
        tick();
        in_valid[1][1] = 1'b0;
        tick();
        n_cmp++; if (out_valid[1][1] !== 1'b0 || fill_level[1][1] !== 3'd1) begin
            n_bad++; $display("FAIL ovs_cutthru_cleared: got valid=%b fill=%0d want 0 1", out_valid[1][1], fill_level[1][1]);
        end
        in_valid[1][1] = 1'b1;
        in_flit[1][1]  = 34'h501;
        in_last[1][1]  = 1'b1;
        tick();
        in_valid[1][1] = 1'b0;
        tick();
        tick();
        n_cmp++; if (fill_level[1][1] !== 3'd0 || out_valid[1][1] !== 1'b0) begin
            n_bad++; $display("FAIL ovs_final_empty: got fill=%0d valid=%b want 0 0", fill_level[1][1], out_valid[1][1]);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        in_valid[1][0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_flit[1][0] = 34'h600 + 34'(i);
            tick();
        end
        idle();
        n_cmp++; if (fill_level[1][0] !== 3'd3) begin n_bad++; $display("FAIL mid_fill: got %0d want 3", fill_level[1][0]); end
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (fill_level[1] !== 6'd0 || in_ready[1] !== 2'b11 || out_valid[1] !== 2'b00) begin
            n_bad++; $display("FAIL mid_async_reset: got fill=%h ready=%b valid=%b want 0 11 00", fill_level[1], in_ready[1], out_valid[1]);
        end
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        in_valid[1][0] = 1'b1;
        in_flit[1][0]  = 34'h700;
        in_last[1][0]  = 1'b1;
        tick();
        idle();
        n_cmp++; if (out_valid[1][0] !== 1'b1 || out_flit[1][0] !== 34'h700 || out_last[1][0] !== 1'b1 || fill_level[1][0] !== 3'd1) begin
            n_bad++; $display("FAIL mid_new_pkt: got v=%b f=%h l=%b fill=%0d want 1 700 1 1", out_valid[1][0], out_flit[1][0], out_last[1][0], fill_level[1][0]);
        end
        out_ready[1][0] = 1'b1;
        tick();
        n_cmp++; if (out_valid[1][0] !== 1'b0 || fill_level[1][0] !== 3'd0) begin
            n_bad++; $display("FAIL mid_drained: got v=%b fill=%0d want 0 0", out_valid[1][0], fill_level[1][0]);
        end
        idle();
    endtask

    task automatic test_random();
        idle();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 2; c++) begin
                    if (!held[d][c]) begin
                        in_valid[d][c] = ($urandom_range(0, 3) != 0);
                        in_flit[d][c]  = {2'($urandom), 32'($urandom)};
                        in_last[d][c]  = ($urandom_range(0, 3) == 0);
                    end
                    out_ready[d][c] = ($urandom_range(0, 2) != 0);
                end
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 2; c++) begin
                    n_cmp++;
                    if (in_ready[d][c] !== m_ready(d, c) || out_valid[d][c] !== m_valid(d, c) ||
                        fill_level[d][c] !== 3'(q[d][c].size()) || oversize[d][c] !== m_over(d, c)) begin
                        n_bad++;
                        $display("FAIL rnd_ctl c%0d d%0d ch%0d: got rdy=%b v=%b fill=%0d ovs=%b want %b %b %0d %b", cyc, d, c,
                                 in_ready[d][c], out_valid[d][c], fill_level[d][c], oversize[d][c],
                                 m_ready(d, c), m_valid(d, c), q[d][c].size(), m_over(d, c));
                    end
                    if (m_valid(d, c)) begin
                        n_cmp++;
                        if (out_flit[d][c] !== q[d][c][0].data || out_last[d][c] !== q[d][c][0].last) begin
                            n_bad++;
                            $display("FAIL rnd_data c%0d d%0d ch%0d: got %h/%b want %h/%b", cyc, d, c,
                                     out_flit[d][c], out_last[d][c], q[d][c][0].data, q[d][c][0].last);
                        end
                    end
                end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_cut_fill();
        test_simul_rw();
        test_packet();
        test_oversize();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
